// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the store write-back path: state encoding and default
// widths/timeout, common with the operand-fetch path.
package mem_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  // Handshake timeout shared with the fetch path.
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_store_unit_slot.sv
// One-deep pending store register: holds a request that arrives while the
// active store is still in flight; load wins over drain in the same edge.
module store_slot
  import mem_store_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store write-back unit: captures a store strobe, drives a single-port memory
// write with ready handshake and timeout. Define STORE_VERIFY_EN for readback verify.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              st_ovf,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              timed_out;
  logic [ADDR_W-1:0] act_addr;
  logic [DATA_W-1:0] act_data;
  logic              load_act, set_err, clr_err;
  logic              slot_valid, slot_load, slot_drain, drop;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;

  assign timed_out = (cnt == CNT_W'(TIMEOUT));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    load_act   = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state)
      IDLE: begin
        if (slot_valid || st_req) begin
          state_next = WRITE;
          load_act   = 1'b1;
          clr_err    = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ready) begin
`ifdef STORE_VERIFY_EN
          state_next = VERIFY;
`else
          state_next = DONE;
`endif
        end else if (timed_out) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
`ifdef STORE_VERIFY_EN
      VERIFY: begin
        if (mem_ready) begin
          set_err    = (mem_rdata != act_data);
          state_next = DONE;
        end else if (timed_out) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        if (slot_valid) begin
          state_next = WRITE;
          load_act   = 1'b1;
          clr_err    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pending request always takes precedence over a fresh strobe for the active regs.
  assign slot_drain = load_act && slot_valid;
  assign slot_load  = st_req && !(state == IDLE && !slot_valid) && (!slot_valid || slot_drain);
  assign drop       = st_req && (state != IDLE) && slot_valid && !slot_drain;

  store_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (slot_load),
    .drain   (slot_drain),
    .in_addr (st_addr),
    .in_data (st_data),
    .valid   (slot_valid),
    .addr    (slot_addr),
    .data    (slot_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (state != IDLE && !timed_out) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the active address/data are reset too, since they drive mem_addr/mem_wdata straight out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_addr <= '0;
      act_data <= '0;
      st_err   <= 1'b0;
      st_ovf   <= 1'b0;
    end else begin
      if (load_act) begin
        act_addr <= slot_valid ? slot_addr : st_addr;
        act_data <= slot_valid ? slot_data : st_data;
      end
      if (clr_err) begin
        st_err <= 1'b0;
      end else if (set_err) begin
        st_err <= 1'b1;
      end
      st_ovf <= drop;
    end
  end

  assign mem_we    = (state == WRITE);
  assign mem_addr  = act_addr;
  assign mem_wdata = act_data;
  assign st_done   = (state == DONE);
  assign st_busy   = (state != IDLE) || slot_valid;

`ifdef STORE_VERIFY_EN
  assign mem_re = (state == VERIFY);
`else
  logic unused_rdata;
  assign mem_re       = 1'b0;
  assign unused_rdata = ^mem_rdata;
`endif

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: table of single stores plus
// hand-written slot/overflow, DONE-coincident strobe, verify and reset sequences.
module tb_mem_store_unit;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;
`ifdef STORE_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_busy, st_done, st_err, st_ovf;
  logic          mem_we, mem_re, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_store_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .st_req    (st_req),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .st_ovf    (st_ovf),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: ready after ready_wait cycles of continuous access.
  int            ready_wait;
  int            act_cnt = 0;
  logic          corrupt;
  logic [DW-1:0] mem [256];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            done_cnt = 0;
  int            ovf_cnt  = 0;

  assign mem_ready = (mem_we || mem_re) && (act_cnt >= ready_wait);
  assign mem_rdata = corrupt ? (mem[mem_addr] ^ 16'h0001) : mem[mem_addr];

  always @(posedge clk) begin
    act_cnt <= (mem_we || mem_re) ? act_cnt + 1 : 0;
    if (mem_we && mem_ready) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      mem[mem_addr] <= mem_wdata;
    end
    if (st_done) done_cnt <= done_cnt + 1;
    if (st_ovf)  ovf_cnt  <= ovf_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_req  = 1'b1;
    st_addr = a;
    st_data = d;
    tick();
    st_req  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && st_busy; i++) tick();
    check("idle_reached", {31'd0, st_busy}, 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            wait_c;
    int            exp_lat;
    int            exp_we;
    int            exp_wr;
    logic          exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int wr0, done_t, we_c, ovf0, done0;
    logic err_s;

    vecs[0] = '{8'h12, 16'hBEEF, 2,  4 + V,  3,  1, 1'b0};
    vecs[1] = '{8'h00, 16'h0000, 0,  2 + V,  1,  1, 1'b0};
    vecs[2] = '{8'hFF, 16'hFFFF, 14, 16 + V, 15, 1, 1'b0};
    vecs[3] = '{8'h80, 16'h1234, 15, 17 + V, 16, 1, 1'b0};
    vecs[4] = '{8'h34, 16'hA5A5, 99, 17,     16, 0, 1'b1};

    rst = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0;
    ready_wait = 0; corrupt = 1'b0;
    #1;
    check("rst_we",   {31'd0, mem_we},  32'd0);
    check("rst_re",   {31'd0, mem_re},  32'd0);
    check("rst_busy", {31'd0, st_busy}, 32'd0);
    check("rst_done", {31'd0, st_done}, 32'd0);
    check("rst_err",  {31'd0, st_err},  32'd0);
    check("rst_ovf",  {31'd0, st_ovf},  32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ready_wait = vecs[v].wait_c;
      wr0 = wr_addr.size();
      strobe(vecs[v].addr, vecs[v].data);
      check($sformatf("v%0d_busy", v), {31'd0, st_busy}, 32'd1);
      check($sformatf("v%0d_we1", v), {31'd0, mem_we}, 32'd1);
      check($sformatf("v%0d_re1", v), {31'd0, mem_re}, 32'd0);
      check($sformatf("v%0d_addr", v), {24'd0, mem_addr}, {24'd0, vecs[v].addr});
      check($sformatf("v%0d_wdata", v), {16'd0, mem_wdata}, {16'd0, vecs[v].data});
      done_t = 0; we_c = 0; err_s = 1'b0;
      for (int t = 1; t <= 40; t++) begin
        if (st_done) begin
          done_t = t;
          err_s  = st_err;
          break;
        end
        if (mem_we) we_c++;
        tick();
      end
      check($sformatf("v%0d_latency", v), done_t, vecs[v].exp_lat);
      check($sformatf("v%0d_we_cycles", v), we_c, vecs[v].exp_we);
      check($sformatf("v%0d_err", v), {31'd0, err_s}, {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_writes", v), wr_addr.size() - wr0, vecs[v].exp_wr);
      if (vecs[v].exp_wr == 1 && wr_addr.size() > wr0) begin
        check($sformatf("v%0d_wr_addr", v), {24'd0, wr_addr[wr0]}, {24'd0, vecs[v].addr});
        check($sformatf("v%0d_wr_data", v), {16'd0, wr_data[wr0]}, {16'd0, vecs[v].data});
      end
      tick();
      check($sformatf("v%0d_idle", v), {31'd0, st_busy}, 32'd0);
    end
    check("err_sticky_idle", {31'd0, st_err}, 32'd1);

    // Three back-to-back strobes: second waits in the slot, third is dropped.
    ready_wait = 3; wr0 = wr_addr.size(); ovf0 = ovf_cnt; done0 = done_cnt;
    strobe(8'h21, 16'h1111);
    check("b2b_err_cleared", {31'd0, st_err}, 32'd0);
    strobe(8'h22, 16'h2222);
    strobe(8'h23, 16'h3333);
    check("b2b_ovf_pulse", {31'd0, st_ovf}, 32'd1);
    tick();
    check("b2b_ovf_one_cycle", {31'd0, st_ovf}, 32'd0);
    wait_idle(100);
    check("b2b_writes", wr_addr.size() - wr0, 2);
    if (wr_addr.size() - wr0 == 2) begin
      check("b2b_first_addr",  {24'd0, wr_addr[wr0]},     32'h21);
      check("b2b_first_data",  {16'd0, wr_data[wr0]},     32'h1111);
      check("b2b_second_addr", {24'd0, wr_addr[wr0 + 1]}, 32'h22);
      check("b2b_second_data", {16'd0, wr_data[wr0 + 1]}, 32'h2222);
    end
    check("b2b_ovf_count",  ovf_cnt - ovf0,   1);
    check("b2b_done_count", done_cnt - done0, 2);

    // Strobe in the DONE cycle with the slot full: drain and refill on one edge.
    ready_wait = 2; wr0 = wr_addr.size(); ovf0 = ovf_cnt; done0 = done_cnt;
    strobe(8'h41, 16'h4444);
    strobe(8'h42, 16'h5555);
    done_t = 0;
    for (int t = 1; t <= 30; t++) begin
      if (st_done) begin
        done_t = t;
        break;
      end
      tick();
    end
    check("dc_done_seen", {31'd0, st_done}, 32'd1);
    check("dc_gap_we_low", {31'd0, mem_we}, 32'd0);
    strobe(8'h43, 16'h6666);
    check("dc_second_we", {31'd0, mem_we}, 32'd1);
    check("dc_second_addr", {24'd0, mem_addr}, 32'h42);
    wait_idle(100);
    check("dc_writes", wr_addr.size() - wr0, 3);
    if (wr_addr.size() - wr0 == 3) begin
      check("dc_order0", {wr_addr[wr0],     wr_data[wr0]},     {8'h41, 16'h4444});
      check("dc_order1", {wr_addr[wr0 + 1], wr_data[wr0 + 1]}, {8'h42, 16'h5555});
      check("dc_order2", {wr_addr[wr0 + 2], wr_data[wr0 + 2]}, {8'h43, 16'h6666});
    end
    check("dc_no_ovf", ovf_cnt - ovf0, 0);
    check("dc_done_count", done_cnt - done0, 3);

`ifdef STORE_VERIFY_EN
    // Readback mismatch, then matching readback.
    ready_wait = 0; corrupt = 1'b1;
    strobe(8'h12, 16'hBEEF);
    tick();
    check("vf_re", {31'd0, mem_re}, 32'd1);
    check("vf_we_low", {31'd0, mem_we}, 32'd0);
    check("vf_addr", {24'd0, mem_addr}, 32'h12);
    tick();
    check("vf_done", {31'd0, st_done}, 32'd1);
    check("vf_err_mismatch", {31'd0, st_err}, 32'd1);
    tick();
    corrupt = 1'b0;
    strobe(8'h12, 16'hBEEF);
    tick();
    tick();
    check("vf_done_match", {31'd0, st_done}, 32'd1);
    check("vf_err_match", {31'd0, st_err}, 32'd0);
    tick();
`endif

    // Reset mid-WRITE with a pending request: both are lost.
    ready_wait = 99;
    strobe(8'h51, 16'h7777);
    strobe(8'h52, 16'h8888);
    tick();
    check("mr_pre_we", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_we",   {31'd0, mem_we},  32'd0);
    check("mr_busy", {31'd0, st_busy}, 32'd0);
    check("mr_err",  {31'd0, st_err},  32'd0);
    check("mr_addr", {24'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_wait = 1; wr0 = wr_addr.size(); done0 = done_cnt;
    tick();
    strobe(8'h53, 16'h9999);
    wait_idle(100);
    check("mr_writes", wr_addr.size() - wr0, 1);
    if (wr_addr.size() > wr0) begin
      check("mr_wr", {wr_addr[wr0], wr_data[wr0]}, {8'h53, 16'h9999});
    end
    check("mr_done_count", done_cnt - done0, 1);
    check("mr_err_after", {31'd0, st_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
